// File: rtl/rob_wb_arbiter_if.sv
// Writeback bus between execution-unit requesters and the ROB writeback arbiter.
// A transfer on requester r happens when req_valid[r] & req_ready[r]; the requester must hold valid/index until ready.
interface rob_wb_arbiter_if #(
    parameter int NUM_REQ = 6,
    parameter int IDX_W   = 7
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     kill;
    logic [3:0]               executed;
    logic [IDX_W-1:0]         executedIndex0;
    logic [IDX_W-1:0]         executedIndex1;
    logic [IDX_W-1:0]         executedIndex2;
    logic [IDX_W-1:0]         executedIndex3;

    modport master (
        output req_valid, req_index, kill,
        input  req_ready, executed,
        input  executedIndex0, executedIndex1, executedIndex2, executedIndex3
    );

    modport slave (
        input  req_valid, req_index, kill,
        output req_ready, executed,
        output executedIndex0, executedIndex1, executedIndex2, executedIndex3
    );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Round-robin writeback arbiter: up to 4 of NUM_REQ completions per cycle into 4 registered ROB lanes.
// Optional conflict counter enabled with macro ROB_WB_ARB_PERF_EN.
module rob_wb_arbiter #(
    parameter  int NUM_REQ = 6,
    parameter  int IDX_W   = 7,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    rob_wb_arbiter_if.slave  wb,
`ifdef ROB_WB_ARB_PERF_EN
    output logic [15:0]      conflict_cnt,
`endif
    output logic [PTR_W-1:0] rr_ptr
);

    logic [IDX_W-1:0] idx_arr [NUM_REQ];
    logic [IDX_W-1:0] lane_idx [4];
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         n_grant;
    logic [PTR_W-1:0]   scan;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   last;
    logic [PTR_W-1:0]   next_ptr;
    logic [3:0]         therm;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign idx_arr[g] = wb.req_index[g*IDX_W +: IDX_W];
    end

    // Scan from rr_ptr; each grant takes the next free lane so lanes fill contiguously.
    always_comb begin
        grant    = '0;
        n_grant  = '0;
        last     = '0;
        scan     = '0;
        scan_sum = '0;
        for (int l = 0; l < 4; l++) lane_idx[l] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            scan = (scan_sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(scan_sum - (PTR_W+1)'(NUM_REQ))
                                                     : PTR_W'(scan_sum);
            if (wb.req_valid[scan] && (n_grant < 3'd4) && !wb.kill && reset) begin
                grant[scan]           = 1'b1;
                lane_idx[n_grant[1:0]] = idx_arr[scan];
                n_grant               = n_grant + 3'd1;
                last                  = scan;
            end
        end
        next_ptr = (last == PTR_W'(NUM_REQ-1)) ? '0 : last + 1'b1;
        case (n_grant)
            3'd0:    therm = 4'b0000;
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            3'd3:    therm = 4'b0111;
            default: therm = 4'b1111;
        endcase
    end

    assign wb.req_ready = grant;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb.executed       <= '0;
            wb.executedIndex0 <= '0;
            wb.executedIndex1 <= '0;
            wb.executedIndex2 <= '0;
            wb.executedIndex3 <= '0;
            rr_ptr            <= '0;
        end else begin
            wb.executed       <= therm;
            wb.executedIndex0 <= lane_idx[0];
            wb.executedIndex1 <= lane_idx[1];
            wb.executedIndex2 <= lane_idx[2];
            wb.executedIndex3 <= lane_idx[3];
            if (n_grant != 3'd0) rr_ptr <= next_ptr;
        end
    end

`ifdef ROB_WB_ARB_PERF_EN
    logic [3:0] n_valid;

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) n_valid = n_valid + 4'(wb.req_valid[i]);
    end

    // Counts cycles where more requesters compete than there are lanes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (!wb.kill && (n_valid > 4'd4) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed vector table, mid-run reset sequence, then random traffic
// checked against a behavioural model through an expected-output queue.
module tb_rob_wb_arbiter;
  localparam int N = 6;
  localparam int W = 7;

  typedef struct {
    logic [5:0]      valid;
    logic [5:0][6:0] idx;
    logic            kill;
    logic [5:0]      ready;
    logic [3:0]      exec;
    logic [3:0][6:0] lanes;
    logic [2:0]      ptr;
  } vec_t;

  logic clk;
  logic reset;
  logic [2:0] rr_ptr;
`ifdef ROB_WB_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] exp_cnt;
`endif

  rob_wb_arbiter_if #(.NUM_REQ(N), .IDX_W(W)) wb ();

  rob_wb_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (wb),
`ifdef ROB_WB_ARB_PERF_EN
    .conflict_cnt (conflict_cnt),
`endif
    .rr_ptr       (rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;
  logic [34:0] exp_q[$];
  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0][6:0] seq_idx(input int base);
    logic [5:0][6:0] v;
    for (int r = 0; r < 6; r++) v[r] = 7'(base + r);
    return v;
  endfunction

  task automatic drive(input logic [5:0] v, input logic [5:0][6:0] ix, input logic k);
    wb.req_valid = v;
    wb.req_index = ix;
    wb.kill      = k;
  endtask

  // Behavioural reference: scan with modulo arithmetic, thermometer from grant count.
  task automatic model(input logic [5:0] v, input logic [5:0][6:0] ix, input logic k,
                       input logic [2:0] p, output logic [5:0] g, output logic [3:0] ex,
                       output logic [3:0][6:0] ln, output logic [2:0] np);
    int n;
    int r;
    n = 0; g = '0; ln = '0; np = p;
    for (int i = 0; i < 6; i++) begin
      r = (int'(p) + i) % 6;
      if (!k && v[r] && n < 4) begin
        g[r] = 1'b1;
        ln[n] = ix[r];
        n++;
        np = 3'((r + 1) % 6);
      end
    end
    ex = 4'((1 << n) - 1);
  endtask

  // scoreboard: pop one expected lane record and compare against the registered outputs
  task automatic sb_check(input string tag);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_executed"}, 32'(wb.executed), 32'(e[34:31]));
      chk({tag, "_idx0"}, 32'(wb.executedIndex0), 32'(e[9:3]));
      chk({tag, "_idx1"}, 32'(wb.executedIndex1), 32'(e[16:10]));
      chk({tag, "_idx2"}, 32'(wb.executedIndex2), 32'(e[23:17]));
      chk({tag, "_idx3"}, 32'(wb.executedIndex3), 32'(e[30:24]));
      chk({tag, "_rr_ptr"}, 32'(rr_ptr), 32'(e[2:0]));
    end
  endtask

  initial begin
    logic [5:0]      pv;
    logic [5:0][6:0] pidx;
    logic            k;
    logic [5:0]      g;
    logic [3:0]      ex;
    logic [3:0][6:0] ln;
    logic [2:0]      m_ptr;
    logic [2:0]      np;

    n_vec = 0;
    n_fail = 0;

    vecs[0]  = '{6'b000101, {7'd0, 7'd0, 7'd0, 7'd9, 7'd0, 7'd5}, 1'b0, 6'b000101, 4'b0011, {7'd0, 7'd0, 7'd9, 7'd5}, 3'd3};
    vecs[1]  = '{6'b100000, {7'd33, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b0, 6'b100000, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd33}, 3'd0};
    vecs[2]  = '{6'b111111, seq_idx(10), 1'b0, 6'b001111, 4'b1111, {7'd13, 7'd12, 7'd11, 7'd10}, 3'd4};
    vecs[3]  = '{6'b110000, seq_idx(10), 1'b0, 6'b110000, 4'b0011, {7'd0, 7'd0, 7'd15, 7'd14}, 3'd0};
    vecs[4]  = '{6'b111111, seq_idx(20), 1'b1, 6'b000000, 4'b0000, {7'd0, 7'd0, 7'd0, 7'd0}, 3'd0};
    vecs[5]  = '{6'b111111, seq_idx(20), 1'b0, 6'b001111, 4'b1111, {7'd23, 7'd22, 7'd21, 7'd20}, 3'd4};
    vecs[6]  = '{6'b110000, seq_idx(20), 1'b0, 6'b110000, 4'b0011, {7'd0, 7'd0, 7'd25, 7'd24}, 3'd0};
    vecs[7]  = '{6'b010000, {7'd0, 7'd40, 7'd0, 7'd0, 7'd0, 7'd0}, 1'b0, 6'b010000, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd40}, 3'd5};
    vecs[8]  = '{6'b100011, seq_idx(30), 1'b0, 6'b100011, 4'b0111, {7'd0, 7'd31, 7'd30, 7'd35}, 3'd2};
    vecs[9]  = '{6'b011100, {6{7'd77}}, 1'b0, 6'b011100, 4'b0111, {7'd0, 7'd77, 7'd77, 7'd77}, 3'd5};
    vecs[10] = '{6'b000000, seq_idx(0), 1'b0, 6'b000000, 4'b0000, {7'd0, 7'd0, 7'd0, 7'd0}, 3'd5};
    vecs[11] = '{6'b111111, seq_idx(50), 1'b0, 6'b100111, 4'b1111, {7'd52, 7'd51, 7'd50, 7'd55}, 3'd3};
    vecs[12] = '{6'b011000, seq_idx(50), 1'b1, 6'b000000, 4'b0000, {7'd0, 7'd0, 7'd0, 7'd0}, 3'd3};
    vecs[13] = '{6'b111000, seq_idx(50), 1'b0, 6'b111000, 4'b0111, {7'd0, 7'd55, 7'd54, 7'd53}, 3'd0};

    // reset with all requesters active: no grants, outputs cleared
    reset = 1'b0;
    drive(6'b111111, seq_idx(1), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(wb.req_ready), 32'd0);
    chk("reset_executed", 32'(wb.executed), 32'd0);
    chk("reset_idx0", 32'(wb.executedIndex0), 32'd0);
    chk("reset_idx3", 32'(wb.executedIndex3), 32'd0);
    chk("reset_rr_ptr", 32'(rr_ptr), 32'd0);
    drive(6'b000000, seq_idx(0), 1'b0);
    reset = 1'b1;
`ifdef ROB_WB_ARB_PERF_EN
    exp_cnt = '0;
`endif

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].idx, vecs[i].kill);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(wb.req_ready), 32'(vecs[i].ready));
      exp_q.push_back({vecs[i].exec, vecs[i].lanes, vecs[i].ptr});
      @(posedge clk);
      #1;
      sb_check($sformatf("vec%0d", i));
    end

    // mid-operation reset while all four lanes are busy
    @(negedge clk);
    drive(6'b111111, seq_idx(90), 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_pre_executed", 32'(wb.executed), 32'hF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(wb.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_executed", 32'(wb.executed), 32'd0);
    chk("midrst_idx0", 32'(wb.executedIndex0), 32'd0);
    chk("midrst_idx1", 32'(wb.executedIndex1), 32'd0);
    chk("midrst_idx2", 32'(wb.executedIndex2), 32'd0);
    chk("midrst_idx3", 32'(wb.executedIndex3), 32'd0);
    chk("midrst_rr_ptr", 32'(rr_ptr), 32'd0);
    @(negedge clk);
    chk("midrst_ready_hold", 32'(wb.req_ready), 32'd0);
    drive(6'b000000, seq_idx(0), 1'b0);
    reset = 1'b1;
`ifdef ROB_WB_ARB_PERF_EN
    exp_cnt = '0;
    chk("perf_after_reset", 32'(conflict_cnt), 32'd0);
`endif

    // random traffic; requesters hold valid/index until granted
    pv = '0;
    pidx = '0;
    m_ptr = 3'd0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int r = 0; r < 6; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) begin
          pv[r] = 1'b1;
          pidx[r] = 7'($urandom_range(0, 127));
        end
      end
      k = ($urandom_range(0, 7) == 0);
      drive(pv, pidx, k);
      #1;
      model(pv, pidx, k, m_ptr, g, ex, ln, np);
      chk("rand_ready", 32'(wb.req_ready), 32'(g));
      exp_q.push_back({ex, ln, np});
`ifdef ROB_WB_ARB_PERF_EN
      if (!k && $countones(pv) > 4 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      @(posedge clk);
      #1;
      sb_check("rand");
`ifdef ROB_WB_ARB_PERF_EN
      chk("rand_conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
`endif
      m_ptr = np;
      pv = pv & ~g;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_wb_arbiter.md
ROB_WB_ARBITER -- requirements
Module: rob_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6, number of execution-unit writeback requesters (legal range 4..8).
REQ-002 Parameter IDX_W, default 7, ROB index width (128-entry ROB).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 req_valid  input  NUM_REQ  per-requester completion request.
REQ-006 req_index  input  NUM_REQ*IDX_W  per-requester ROB index; requester r occupies bits [r*IDX_W +: IDX_W].
REQ-007 req_ready  output  NUM_REQ  per-requester grant; combinational, transfer = req_valid[r] & req_ready[r].
REQ-008 kill  input  1  pipeline flush; suppresses all grants in the current cycle.
REQ-009 executed  output  4  registered ROB execute-lane strobes.
REQ-010 executedIndex0..executedIndex3  output  IDX_W each  registered ROB index for lanes 0..3.

Function
REQ-011 Arbiter SHALL grant at most 4 requesters per cycle, selected round-robin starting from rr_ptr, scanning r = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
REQ-012 req_ready[r] SHALL be 1 only when req_valid[r]=1, kill=0, reset=1, and r is among the first 4 valid requesters in scan order.
REQ-013 Requester SHALL hold req_valid and req_index stable until req_ready; arbiter makes no other assumption.
REQ-014 Granted requesters SHALL fill lanes contiguously from lane 0 in scan order; executed SHALL be thermometer-coded (0000, 0001, 0011, 0111, 1111).
REQ-015 Latency: handshake in cycle N SHALL appear on executed/executedIndexK in cycle N+1; no grants in cycle N -> executed=0000 in N+1.
REQ-016 Unused lanes SHALL drive executedIndexK = 0.
REQ-017 rr_ptr SHALL update to (last granted requester + 1) mod NUM_REQ when at least one grant occurs; unchanged otherwise; wrap from NUM_REQ-1 to 0.
REQ-018 kill=1: no grants, executed=0000 next cycle, rr_ptr unchanged; kill concurrent with any valid pattern has priority.
REQ-019 Duplicate req_index values from different requesters SHALL both be granted and forwarded unmodified; no dedup.
REQ-020 Fewer than or equal to 4 valid requesters SHALL all be granted in the same cycle (no bubbles).
REQ-021 rr_ptr width SHALL be ceil(log2(NUM_REQ)); wrap arithmetic SHALL not overflow to values >= NUM_REQ.

Reset
REQ-022 reset=0 at posedge SHALL clear executed to 0000, executedIndex0..3 to 0, rr_ptr to 0, and perf counter (if present) to 0.
REQ-023 While reset=0, req_ready SHALL be all zeros; no handshake occurs.
REQ-024 Reset asserted mid-operation SHALL discard in-flight lane data; first post-reset cycle outputs executed=0000.

Configuration
REQ-025 Macro ROB_WB_ARB_PERF_EN: when defined, module SHALL add output conflict_cnt (16 bits), incrementing by 1 each non-reset cycle with kill=0 and more than 4 valid requesters, saturating at 0xFFFF.
REQ-026 Without ROB_WB_ARB_PERF_EN the conflict_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, then req_valid=6'b000101, indices r0=5, r2=9 -> next cycle executed=0011, idx0=5, idx1=9, rr_ptr=3.
REQ-028 rr_ptr=0, all 6 valid, indices r=10+r -> grants r0..r3, next cycle executed=1111, idx=10,11,12,13; following cycle (held r4,r5) executed=0011, idx=14,15, rr_ptr=0.
REQ-029 rr_ptr=5, req_valid=6'b100011 -> scan order r5,r0,r1; executed=0111 next cycle with idx0=r5 index, rr_ptr=2.
REQ-030 kill=1 with all 6 valid -> req_ready=000000, executed=0000 next cycle, rr_ptr unchanged; kill=0 next cycle resumes from same rr_ptr.
REQ-031 reset=0 asserted while executed=1111 -> next cycle executed=0000, all indices 0, req_ready=0 throughout reset.
REQ-032 With ROB_WB_ARB_PERF_EN, 3 consecutive cycles of 6 valid requesters -> conflict_cnt=3; preload near 0xFFFF -> holds 0xFFFF.
